boss_bullet_pool: RTL and testbench

Parametrised boss-bullet engine for the boss stage: a pool of `NUM_SLOTS` independent bullet slots, a spawn sequencer that fires bursts in one of three selectable patterns, per-slot signed velocity with wall bounce, and player-hitbox collision. It sits between the boss movement logic (`bossx`/`bossy`) and the VGA sprite mux and player-life logic. It replaces the fixed five-plus-one bullet generator with a generic, pattern-selectable pool.

---
 rtl/boss_bullet_pool.sv | 219 +++++++++++++++++++++
 tb/tb_boss_bullet_pool.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/boss_bullet_pool.sv
// Boss bullet pool: burst sequencer (fan / aimed / rain) feeding NUM_SLOTS bullet slots that move,
// bounce off the side walls, despawn at the bottom and report player hits. All outputs are registered.
module boss_bullet_pool #(
    parameter int NUM_SLOTS   = 8,
    parameter int BURST_LEN   = 5,
    parameter int FIRE_PERIOD = 24,
    parameter int VY          = 4,
    parameter int VMAX        = 8,
    parameter int X_MIN       = 30,
    parameter int X_MAX       = 410,
    parameter int Y_MAX       = 472,
    parameter int HIT_R       = 10
) (
    input  logic                    clk22,
    input  logic                    rst,
    input  logic                    gamestart,
    input  logic                    boss,
    input  logic                    fire_en,
    input  logic [1:0]              mode,
    input  logic [9:0]              bossx,
    input  logic [9:0]              bossy,
    input  logic [9:0]              reimux,
    input  logic [9:0]              reimuy,
    output logic [NUM_SLOTS-1:0]    bullet_valid,
    output logic [10*NUM_SLOTS-1:0] bullet_x,
    output logic [10*NUM_SLOTS-1:0] bullet_y,
    output logic                    hit,
    output logic [7:0]              hit_count,
    output logic                    busy
);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_COOL} state_t;

    localparam int KW        = 4;
    localparam int CW        = $clog2(FIRE_PERIOD);
    localparam int RAIN_STEP = (X_MAX - X_MIN) / BURST_LEN;

    localparam logic signed [10:0] VMAX_P = 11'(VMAX);
    localparam logic signed [10:0] VMAX_N = 11'(-VMAX);
    localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
    localparam logic signed [10:0] XMAX_S = 11'(X_MAX);

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0]  valid_q, valid_d;
    logic [9:0]            x_q  [NUM_SLOTS];
    logic [9:0]            x_d  [NUM_SLOTS];
    logic [9:0]            y_q  [NUM_SLOTS];
    logic [9:0]            y_d  [NUM_SLOTS];
    logic signed [4:0]     vx_q [NUM_SLOTS];
    logic signed [4:0]     vx_d [NUM_SLOTS];
    logic                  hit_q, hit_d;
    logic [7:0]            hit_count_q, hit_count_d;

    logic                  clear;
    logic [NUM_SLOTS-1:0]  coll;
    logic [NUM_SLOTS-1:0]  spawn_sel;
    logic                  taken;
    logic signed [10:0]    fan_raw, aim_diff, aim_sh;
    logic [9:0]            sp_x, sp_y;
    logic signed [4:0]     sp_vx;

    assign clear = gamestart | ~boss;

    function automatic logic [9:0] absdiff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic signed [4:0] clamp_v(input logic signed [10:0] v);
        if (v > VMAX_P)      return VMAX_P[4:0];
        else if (v < VMAX_N) return VMAX_N[4:0];
        else                 return v[4:0];
    endfunction

    // Returns {vx, x}; a wall hit pins x to the wall and reflects vx.
    function automatic logic [14:0] step_x(input logic [9:0] x, input logic signed [4:0] vx);
        logic signed [10:0] nx;
        logic signed [4:0]  nvx;
        nx  = $signed({1'b0, x}) + $signed({{6{vx[4]}}, vx});
        nvx = -vx;
        if (nx < XMIN_S)      return {nvx, 10'(X_MIN)};
        else if (nx > XMAX_S) return {nvx, 10'(X_MAX)};
        else                  return {vx, nx[9:0]};
    endfunction

    always_comb begin
        fan_raw  = $signed({6'b0, k_q, 1'b0}) - $signed(11'(BURST_LEN - 1));
        aim_diff = $signed({1'b0, reimux}) - $signed({1'b0, bossx});
        aim_sh   = aim_diff >>> 4;
        sp_x     = bossx;
        sp_y     = bossy;
        sp_vx    = clamp_v(fan_raw);
        case (mode)
            2'd1: sp_vx = clamp_v(aim_sh);
            2'd2: begin
                sp_x  = 10'(X_MIN + int'(k_q) * RAIN_STEP);
                sp_y  = 10'd0;
                sp_vx = 5'sd0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = S_IDLE;
            k_d     = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: if (fire_en) begin
                    state_d = S_BURST;
                    k_d     = '0;
                end
                S_BURST: if (k_q == KW'(BURST_LEN - 1)) begin
                    state_d = S_COOL;
                    k_d     = '0;
                    cnt_d   = CW'(FIRE_PERIOD - 1);
                end else begin
                    k_d = k_q + KW'(1);
                end
                S_COOL: if (cnt_q == '0) begin
                    state_d = fire_en ? S_BURST : S_IDLE;
                    k_d     = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        valid_d   = valid_q;
        coll      = '0;
        spawn_sel = '0;
        taken     = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            x_d[i]  = x_q[i];
            y_d[i]  = y_q[i];
            vx_d[i] = vx_q[i];
        end
        // Spawn target is picked from the start-of-tick valid mask, so slots freed now wait a tick.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            spawn_sel[i] = ~valid_q[i] & ~taken;
            taken        = taken | ~valid_q[i];
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (clear) begin
                valid_d[i] = 1'b0;
            end else if (valid_q[i]) begin
                if ((absdiff(x_q[i], reimux) < 10'(HIT_R)) &&
                    (absdiff(y_q[i], reimuy) < 10'(HIT_R))) begin
                    coll[i]    = 1'b1;
                    valid_d[i] = 1'b0;
                end else if (({1'b0, y_q[i]} + 11'(VY)) > 11'(Y_MAX)) begin
                    valid_d[i] = 1'b0;
                end else begin
                    y_d[i]             = y_q[i] + 10'(VY);
                    {vx_d[i], x_d[i]}  = step_x(x_q[i], vx_q[i]);
                end
            end else if (spawn_sel[i] && (state_q == S_BURST)) begin
                valid_d[i] = 1'b1;
                x_d[i]     = sp_x;
                y_d[i]     = sp_y;
                vx_d[i]    = sp_vx;
            end
        end
        hit_d       = |coll;
        hit_count_d = (hit_d && (hit_count_q != 8'hFF)) ? hit_count_q + 8'd1 : hit_count_q;
    end

    always_ff @(posedge clk22 or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            valid_q     <= '0;
            hit_q       <= 1'b0;
            hit_count_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i]  <= '0;
                y_q[i]  <= '0;
                vx_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            hit_q       <= hit_d;
            hit_count_q <= hit_count_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i]  <= x_d[i];
                y_q[i]  <= y_d[i];
                vx_q[i] <= vx_d[i];
            end
        end
    end

    always_comb begin
        bullet_x = '0;
        bullet_y = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            bullet_x[10*i +: 10] = x_q[i];
            bullet_y[10*i +: 10] = y_q[i];
        end
    end

    assign bullet_valid = valid_q;
    assign hit          = hit_q;
    assign hit_count    = hit_count_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_boss_bullet_pool.sv
// Directed bench for boss_bullet_pool: an 8-slot instance plus a 4-slot instance for pool exhaustion.
module tb_boss_bullet_pool;

    logic        clk22 = 1'b0;
    logic        rst, gamestart, boss, fire_en;
    logic [1:0]  mode;
    logic [9:0]  bossx, bossy, reimux, reimuy;

    logic [7:0]  bv;
    logic [79:0] bxv, byv;
    logic        hit;
    logic [7:0]  hc;
    logic        busy;

    logic [3:0]  bv4;
    logic [39:0] bx4, by4;
    logic        hit4;
    logic [7:0]  hc4;
    logic        busy4;

    int checks   = 0;
    int failures = 0;

    always #5 clk22 = ~clk22;

    boss_bullet_pool dut (
        .clk22(clk22), .rst(rst), .gamestart(gamestart), .boss(boss), .fire_en(fire_en),
        .mode(mode), .bossx(bossx), .bossy(bossy), .reimux(reimux), .reimuy(reimuy),
        .bullet_valid(bv), .bullet_x(bxv), .bullet_y(byv),
        .hit(hit), .hit_count(hc), .busy(busy)
    );

    boss_bullet_pool #(.NUM_SLOTS(4)) dut4 (
        .clk22(clk22), .rst(rst), .gamestart(gamestart), .boss(boss), .fire_en(fire_en),
        .mode(mode), .bossx(bossx), .bossy(bossy), .reimux(reimux), .reimuy(reimuy),
        .bullet_valid(bv4), .bullet_x(bx4), .bullet_y(by4),
        .hit(hit4), .hit_count(hc4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] sx(input int i);
        return bxv[10*i +: 10];
    endfunction

    function automatic logic [9:0] sy(input int i);
        return byv[10*i +: 10];
    endfunction

    task automatic tick;
        @(posedge clk22);
        #1;
    endtask

    initial begin
        rst = 1'b0; gamestart = 1'b0; boss = 1'b1; fire_en = 1'b0; mode = 2'd0;
        bossx = 10'd200; bossy = 10'd50; reimux = 10'd600; reimuy = 10'd600;
        #3;
        chk("rst_valid", 32'(bv), 0);
        chk("rst_x", 32'(|bxv), 0);
        chk("rst_y", 32'(|byv), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_hc", 32'(hc), 0);
        chk("rst_busy", 32'(busy), 0);
        tick; tick;
        rst = 1'b1;
        tick;
        chk("idle_busy", 32'(busy), 0);

        // Fan burst, fire_en held so the second burst start can be timed.
        fire_en = 1'b1;
        tick;                                   // t: BURST entered
        chk("fan_busy", 32'(busy), 1);
        chk("fan_nospawn_yet", 32'(bv), 0);
        tick;                                   // t+1
        chk("fan_v1", 32'(bv), 32'h01);
        chk("fan_x0_spawn", 32'(sx(0)), 200);
        chk("fan_y0_spawn", 32'(sy(0)), 50);
        tick;                                   // t+2
        chk("fan_x0_move", 32'(sx(0)), 196);
        chk("fan_y0_move", 32'(sy(0)), 54);
        chk("fan_v2", 32'(bv), 32'h03);
        tick; tick; tick;                       // t+5
        chk("fan_v5", 32'(bv), 32'h1F);
        chk("pool4_full", 32'(bv4), 32'hF);
        chk("pool4_busy", 32'(busy4), 1);
        tick;                                   // t+6
        chk("fan_x0", 32'(sx(0)), 180);
        chk("fan_y0", 32'(sy(0)), 70);
        chk("fan_x1", 32'(sx(1)), 192);
        chk("fan_x2", 32'(sx(2)), 200);
        chk("fan_x3", 32'(sx(3)), 204);
        chk("fan_x4", 32'(sx(4)), 204);
        chk("pool4_x3", 32'(bx4[39:30]), 204);
        repeat (23) tick;                       // t+29
        chk("period_no_spawn", 32'(bv), 32'h1F);
        tick;                                   // t+30
        chk("period_spawn", 32'(bv), 32'h3F);
        fire_en = 1'b0;
        tick; tick;                             // t+32
        chk("burst_not_aborted", 32'(bv), 32'hFF);
        chk("pool4_still_full", 32'(bv4), 32'hF);
        repeat (25) tick;                       // t+57
        chk("cool_busy_last", 32'(busy), 1);
        chk("pool4_busy_last", 32'(busy4), 1);
        tick;                                   // t+58
        chk("cool_idle", 32'(busy), 0);
        chk("pool4_idle", 32'(busy4), 0);
        gamestart = 1'b1;
        tick;
        chk("gs_valid", 32'(bv), 0);
        chk("gs_valid4", 32'(bv4), 0);
        gamestart = 1'b0;

        // Bounce: aimed vx = (0-114)>>>4 = -8.
        mode = 2'd1; bossx = 10'd114; bossy = 10'd50; reimux = 10'd0; reimuy = 10'd600;
        fire_en = 1'b1;
        tick;                                   // a
        fire_en = 1'b0;
        tick;                                   // a+1
        chk("bnc_spawn", 32'(sx(0)), 114);
        repeat (10) tick;                       // a+11
        chk("bnc_x34", 32'(sx(0)), 34);
        tick;
        chk("bnc_wall", 32'(sx(0)), 30);
        tick;
        chk("bnc_after", 32'(sx(0)), 38);
        chk("bnc_y", 32'(sy(0)), 98);
        boss = 1'b0;
        tick;
        chk("boss_clr_valid", 32'(bv), 0);
        chk("boss_clr_busy", 32'(busy), 0);
        boss = 1'b1;

        // Aimed clamp to +8, then aimed -4, then rain.
        mode = 2'd1; bossx = 10'd40; reimux = 10'd400;
        fire_en = 1'b1;
        tick;                                   // b
        fire_en = 1'b0;
        tick;                                   // b+1
        chk("aim_spawn", 32'(sx(0)), 40);
        tick;                                   // b+2
        chk("aim_clamp", 32'(sx(0)), 48);
        bossx = 10'd100; reimux = 10'd40;
        tick;                                   // b+3
        mode = 2'd2;
        tick;                                   // b+4
        chk("aim_neg", 32'(sx(2)), 96);
        chk("rain_x3", 32'(sx(3)), 258);
        chk("rain_y3", 32'(sy(3)), 0);
        tick;                                   // b+5
        chk("rain_x4", 32'(sx(4)), 334);
        chk("rain_y3_move", 32'(sy(3)), 4);
        boss = 1'b0;
        tick;
        boss = 1'b1;

        // Collision beats despawn; lone bottom bullet despawns silently.
        mode = 2'd0; bossx = 10'd200; bossy = 10'd470; reimux = 10'd200; reimuy = 10'd470;
        fire_en = 1'b1;
        tick;                                   // s
        fire_en = 1'b0;
        tick;                                   // s+1
        chk("col_pre_hit", 32'(hit), 0);
        chk("col_pre_valid", 32'(bv), 32'h01);
        tick;                                   // s+2
        chk("col_hit", 32'(hit), 1);
        chk("col_hc", 32'(hc), 1);
        chk("col_valid", 32'(bv), 32'h02);
        reimux = 10'd210;                       // |dx| = 10, just outside the hitbox
        tick;                                   // s+3
        chk("desp_hit", 32'(hit), 0);
        chk("desp_hc", 32'(hc), 1);
        chk("desp_reuse", 32'(bv), 32'h01);
        tick; tick; tick;                       // s+6
        chk("desp_empty", 32'(bv), 0);
        chk("desp_hc_end", 32'(hc), 1);
        gamestart = 1'b1;
        tick;
        chk("gs_hc_kept", 32'(hc), 1);
        chk("gs_hit", 32'(hit), 0);
        chk("gs_busy", 32'(busy), 0);
        gamestart = 1'b0;

        // Asynchronous reset in the middle of a burst.
        mode = 2'd0; bossy = 10'd50; reimux = 10'd600; reimuy = 10'd600;
        fire_en = 1'b1;
        tick; tick; tick;
        chk("mid_pre", 32'(bv), 32'h03);
        rst = 1'b0;
        #2;
        chk("arst_valid", 32'(bv), 0);
        chk("arst_hc", 32'(hc), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_x", 32'(|bxv), 0);
        chk("arst_y", 32'(|byv), 0);
        #5;
        rst = 1'b1;
        fire_en = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
